voice_allocator: RTL and testbench

//   Shares NUM_VOICES tone generators among key events from the matrix-keyboard decoder.

---
 rtl/voice_allocator_if.sv | 29 ++
 rtl/voice_allocator.sv | 166 ++++++++++++++++
 tb/tb_voice_allocator.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/voice_allocator_if.sv
// Event-in / voice-out bundle between the keyboard note-event stage, the voice
// allocator and the per-voice tone generators.
interface voice_allocator_if #(
    parameter int NUM_VOICES = 4,
    parameter int NOTE_W     = 8
);
    localparam int CNT_W = $clog2(NUM_VOICES + 1);

    logic                         ev_valid;
    logic                         ev_ready;
    logic                         ev_on;
    logic [NOTE_W-1:0]            ev_note;
    logic                         all_off;
    logic [NUM_VOICES-1:0]        voice_en;
    logic [NUM_VOICES*NOTE_W-1:0] voice_note;
    logic [NUM_VOICES-1:0]        voice_load;
    logic [CNT_W-1:0]             active_cnt;
    logic [7:0]                   steal_cnt;

    modport master (
        output ev_valid, ev_on, ev_note, all_off,
        input  ev_ready, voice_en, voice_note, voice_load, active_cnt, steal_cnt
    );

    modport slave (
        input  ev_valid, ev_on, ev_note, all_off,
        output ev_ready, voice_en, voice_note, voice_load, active_cnt, steal_cnt
    );
endinterface

// File: rtl/voice_allocator.sv
// Assigns note-on events to tone generators (retrigger, lowest free, or
// round-robin steal) and releases voices on note-off; 3 cycles per event.
module voice_allocator #(
    parameter int NUM_VOICES = 4,
    parameter int NOTE_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    voice_allocator_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_VOICES);
    localparam int CNT_W = $clog2(NUM_VOICES + 1);

    typedef enum logic [1:0] {S_IDLE, S_MATCH, S_COMMIT} state_t;
    typedef enum logic [2:0] {A_NONE, A_RETRIG, A_TAKE, A_STEAL, A_OFF} action_t;

    state_t                state_reg,       state_next;
    action_t               action_reg,      action_next;
    logic                  ev_on_reg,       ev_on_next;
    logic [NOTE_W-1:0]     ev_note_reg,     ev_note_next;
    logic [IDX_W-1:0]      target_reg,      target_next;
    logic [NUM_VOICES-1:0] voice_en_reg,    voice_en_next;
    logic [NOTE_W-1:0]     voice_note_reg   [NUM_VOICES];
    logic [NOTE_W-1:0]     voice_note_next  [NUM_VOICES];
    logic [NUM_VOICES-1:0] voice_load_reg,  voice_load_next;
    logic [CNT_W-1:0]      active_cnt_reg,  active_cnt_next;
    logic [7:0]            steal_cnt_reg,   steal_cnt_next;
    logic [IDX_W-1:0]      steal_ptr_reg,   steal_ptr_next;

    logic                  ev_ready;
    logic [NUM_VOICES-1:0] hit;
    logic [NUM_VOICES-1:0] free;
    logic [IDX_W-1:0]      hit_idx;
    logic [IDX_W-1:0]      free_idx;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
            assign hit[gi] = voice_en_reg[gi] && (voice_note_reg[gi] == ev_note_reg);
            assign bus.voice_note[gi*NOTE_W +: NOTE_W] = voice_note_reg[gi];
        end
    endgenerate

    assign free = ~voice_en_reg;

    // Descending scan so the lowest matching index wins.
    always_comb begin
        hit_idx  = '0;
        free_idx = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (hit[i])  hit_idx  = IDX_W'(i);
            if (free[i]) free_idx = IDX_W'(i);
        end
    end

    always_comb begin
        state_next      = state_reg;
        action_next     = action_reg;
        ev_on_next      = ev_on_reg;
        ev_note_next    = ev_note_reg;
        target_next     = target_reg;
        voice_en_next   = voice_en_reg;
        voice_note_next = voice_note_reg;
        voice_load_next = '0;
        steal_ptr_next  = steal_ptr_reg;
        steal_cnt_next  = steal_cnt_reg;
        ev_ready        = (state_reg == S_IDLE) && !bus.all_off;

        case (state_reg)
            S_IDLE: begin
                if (bus.ev_valid && ev_ready) begin
                    ev_on_next   = bus.ev_on;
                    ev_note_next = bus.ev_note;
                    state_next   = S_MATCH;
                end
            end
            S_MATCH: begin
                state_next = S_COMMIT;
                if (!ev_on_reg) begin
                    action_next = A_OFF;
                end else if (ev_note_reg == '0) begin
                    action_next = A_NONE;
                end else if (|hit) begin
                    action_next = A_RETRIG;
                    target_next = hit_idx;
                end else if (|free) begin
                    action_next = A_TAKE;
                    target_next = free_idx;
                end else begin
                    action_next = A_STEAL;
                    target_next = steal_ptr_reg;
                end
            end
            S_COMMIT: begin
                state_next = S_IDLE;
                case (action_reg)
                    A_RETRIG: voice_load_next[target_reg] = 1'b1;
                    A_TAKE: begin
                        voice_en_next[target_reg]   = 1'b1;
                        voice_note_next[target_reg] = ev_note_reg;
                        voice_load_next[target_reg] = 1'b1;
                    end
                    A_STEAL: begin
                        voice_note_next[target_reg] = ev_note_reg;
                        voice_load_next[target_reg] = 1'b1;
                        steal_ptr_next = (steal_ptr_reg == IDX_W'(NUM_VOICES - 1))
                                         ? '0 : steal_ptr_reg + 1'b1;
                        if (steal_cnt_reg != 8'hFF) steal_cnt_next = steal_cnt_reg + 8'd1;
                    end
                    // Voice state cannot change between MATCH and COMMIT, so the live hit mask is still valid.
                    A_OFF:   voice_en_next = voice_en_reg & ~hit;
                    default: ;
                endcase
            end
            default: state_next = S_IDLE;
        endcase

        if (bus.all_off) begin
            state_next      = S_IDLE;
            voice_en_next   = '0;
            voice_load_next = '0;
            steal_ptr_next  = '0;
        end
    end

    always_comb begin
        active_cnt_next = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            active_cnt_next = active_cnt_next + CNT_W'(voice_en_next[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            action_reg     <= A_NONE;
            ev_on_reg      <= 1'b0;
            ev_note_reg    <= '0;
            target_reg     <= '0;
            voice_en_reg   <= '0;
            voice_note_reg <= '{default: '0};
            voice_load_reg <= '0;
            active_cnt_reg <= '0;
            steal_cnt_reg  <= '0;
            steal_ptr_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            action_reg     <= action_next;
            ev_on_reg      <= ev_on_next;
            ev_note_reg    <= ev_note_next;
            target_reg     <= target_next;
            voice_en_reg   <= voice_en_next;
            voice_note_reg <= voice_note_next;
            voice_load_reg <= voice_load_next;
            active_cnt_reg <= active_cnt_next;
            steal_cnt_reg  <= steal_cnt_next;
            steal_ptr_reg  <= steal_ptr_next;
        end
    end

    assign bus.ev_ready   = ev_ready;
    assign bus.voice_en   = voice_en_reg;
    assign bus.voice_load = voice_load_reg;
    assign bus.active_cnt = active_cnt_reg;
    assign bus.steal_cnt  = steal_cnt_reg;
endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: directed vector table, hand-written panic/reset
// sequences, and randomized events checked against a behavioural voice model.
module tb_voice_allocator;
    localparam int NV = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    voice_allocator_if #(.NUM_VOICES(NV), .NOTE_W(8)) bus ();
    voice_allocator #(.NUM_VOICES(NV), .NOTE_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural model of the voice bank.
    bit         m_en   [NV];
    logic [7:0] m_note [NV];
    int         m_ptr;
    int         m_scnt;

    typedef struct {
        bit          on;
        logic [7:0]  note;
        logic [3:0]  en;
        logic [3:0]  load;
        logic [31:0] notes;
        int          active;
        int          steals;
    } vec_t;
    vec_t vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_reset(input bit keep_notes);
        for (int i = 0; i < NV; i++) begin
            m_en[i] = 1'b0;
            if (!keep_notes) m_note[i] = 8'h00;
        end
        m_ptr = 0;
        if (!keep_notes) m_scnt = 0;
    endfunction

    function automatic void model_apply(input bit on, input logic [7:0] n, output logic [3:0] load);
        int slot;
        load = 4'b0000;
        slot = -1;
        if (on) begin
            if (n == 8'h00) return;
            for (int i = 0; i < NV; i++) if (slot < 0 && m_en[i] && m_note[i] == n) slot = i;
            if (slot >= 0) begin
                load[slot] = 1'b1;
                return;
            end
            for (int i = 0; i < NV; i++) if (slot < 0 && !m_en[i]) slot = i;
            if (slot < 0) begin
                slot  = m_ptr;
                m_ptr = (m_ptr + 1) % NV;
                if (m_scnt < 255) m_scnt++;
            end
            m_en[slot]   = 1'b1;
            m_note[slot] = n;
            load[slot]   = 1'b1;
        end else begin
            for (int i = 0; i < NV; i++) if (m_en[i] && m_note[i] == n) m_en[i] = 1'b0;
        end
    endfunction

    function automatic logic [3:0] m_en_vec();
        logic [3:0] v;
        for (int i = 0; i < NV; i++) v[i] = m_en[i];
        return v;
    endfunction

    function automatic logic [31:0] m_note_vec();
        logic [31:0] v;
        for (int i = 0; i < NV; i++) v[i*8 +: 8] = m_note[i];
        return v;
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < NV; i++) c += int'(m_en[i]);
        return c;
    endfunction

    // Offer one event, follow it through MATCH/COMMIT, and return outputs sampled after E2.
    task automatic send_event(input bit on, input logic [7:0] note,
                              output logic [3:0] en, output logic [31:0] notes,
                              output logic [3:0] load, output logic [2:0] act,
                              output logic [7:0] sc);
        int k;
        logic [3:0] en_before;
        @(negedge clk);
        k = 0;
        while (!bus.ev_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("ready_wait", 64'(bus.ev_ready), 64'd1);
        en_before    = bus.voice_en;
        bus.ev_valid = 1'b1;
        bus.ev_on    = on;
        bus.ev_note  = note;
        @(posedge clk); #1;
        check("ready_in_match", 64'(bus.ev_ready), 64'd0);
        bus.ev_valid = 1'b0;
        bus.ev_on    = ~on;
        bus.ev_note  = 8'($urandom);
        @(posedge clk); #1;
        check("ready_in_commit", 64'(bus.ev_ready), 64'd0);
        check("en_before_e2", 64'(bus.voice_en), 64'(en_before));
        check("load_before_e2", 64'(bus.voice_load), 64'd0);
        @(posedge clk); #1;
        check("ready_after_e2", 64'(bus.ev_ready), 64'd1);
        en    = bus.voice_en;
        notes = bus.voice_note;
        load  = bus.voice_load;
        act   = bus.active_cnt;
        sc    = bus.steal_cnt;
        @(posedge clk); #1;
        check("load_one_cycle", 64'(bus.voice_load), 64'd0);
        $display("evt %s note=%02h -> en=%b load=%b notes=%08h active=%0d steals=%0d",
                 on ? "on " : "off", note, en, load, notes, act, sc);
    endtask

    task automatic run_checked(input bit on, input logic [7:0] note);
        logic [3:0]  en, load, exp_load;
        logic [31:0] notes;
        logic [2:0]  act;
        logic [7:0]  sc;
        send_event(on, note, en, notes, load, act, sc);
        model_apply(on, note, exp_load);
        check("model_en", 64'(en), 64'(m_en_vec()));
        check("model_notes", 64'(notes), 64'(m_note_vec()));
        check("model_load", 64'(load), 64'(exp_load));
        check("model_active", 64'(act), 64'(m_count()));
        check("model_steals", 64'(sc), 64'(m_scnt));
    endtask

    task automatic pulse_all_off();
        @(negedge clk);
        bus.all_off = 1'b1;
        @(negedge clk);
        bus.all_off = 1'b0;
        model_reset(1'b1);
        #1;
        check("all_off_en", 64'(bus.voice_en), 64'd0);
        check("all_off_active", 64'(bus.active_cnt), 64'd0);
        $display("evt all_off -> en=%b", bus.voice_en);
    endtask

    initial begin
        logic [3:0]  en, load, dummy;
        logic [31:0] notes;
        logic [2:0]  act;
        logic [7:0]  sc;

        //           on    note   en    load   notes         act st
        vecs[0]  = '{1'b1, 8'h04, 4'h1, 4'h1, 32'h00000004, 1, 0};
        vecs[1]  = '{1'b1, 8'h05, 4'h3, 4'h2, 32'h00000504, 2, 0};
        vecs[2]  = '{1'b1, 8'h40, 4'h7, 4'h4, 32'h00400504, 3, 0};
        vecs[3]  = '{1'b1, 8'h50, 4'hF, 4'h8, 32'h50400504, 4, 0};
        vecs[4]  = '{1'b1, 8'h03, 4'hF, 4'h1, 32'h50400503, 4, 1};
        vecs[5]  = '{1'b1, 8'h06, 4'hF, 4'h2, 32'h50400603, 4, 2};
        vecs[6]  = '{1'b0, 8'h06, 4'hD, 4'h0, 32'h50400603, 3, 2};
        vecs[7]  = '{1'b1, 8'h30, 4'hF, 4'h2, 32'h50403003, 4, 2};
        vecs[8]  = '{1'b1, 8'h40, 4'hF, 4'h4, 32'h50403003, 4, 2};
        vecs[9]  = '{1'b1, 8'h00, 4'hF, 4'h0, 32'h50403003, 4, 2};
        vecs[10] = '{1'b0, 8'h77, 4'hF, 4'h0, 32'h50403003, 4, 2};
        vecs[11] = '{1'b1, 8'h03, 4'hF, 4'h1, 32'h50403003, 4, 2};
        vecs[12] = '{1'b1, 8'h11, 4'hF, 4'h4, 32'h50113003, 4, 3};

        rst          = 1'b1;
        bus.ev_valid = 1'b0;
        bus.ev_on    = 1'b0;
        bus.ev_note  = 8'h00;
        bus.all_off  = 1'b0;
        model_reset(1'b0);
        #3;
        check("reset_en", 64'(bus.voice_en), 64'd0);
        check("reset_notes", 64'(bus.voice_note), 64'd0);
        check("reset_load", 64'(bus.voice_load), 64'd0);
        check("reset_active", 64'(bus.active_cnt), 64'd0);
        check("reset_steals", 64'(bus.steal_cnt), 64'd0);
        check("reset_ready", 64'(bus.ev_ready), 64'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            send_event(vecs[i].on, vecs[i].note, en, notes, load, act, sc);
            model_apply(vecs[i].on, vecs[i].note, dummy);
            check("vec_en", 64'(en), 64'(vecs[i].en));
            check("vec_load", 64'(load), 64'(vecs[i].load));
            check("vec_notes", 64'(notes), 64'(vecs[i].notes));
            check("vec_active", 64'(act), 64'(vecs[i].active));
            check("vec_steals", 64'(sc), 64'(vecs[i].steals));
        end

        // Panic during MATCH of on 0x07: event lost, voices silenced, notes kept.
        @(negedge clk);
        bus.ev_valid = 1'b1; bus.ev_on = 1'b1; bus.ev_note = 8'h07;
        @(posedge clk); #1;
        bus.ev_valid = 1'b0;
        @(negedge clk);
        bus.all_off = 1'b1;
        @(posedge clk); #1;
        check("abort_en", 64'(bus.voice_en), 64'd0);
        check("abort_active", 64'(bus.active_cnt), 64'd0);
        check("abort_notes", 64'(bus.voice_note), 64'h50113003);
        check("abort_steals", 64'(bus.steal_cnt), 64'd3);
        check("abort_ready_low", 64'(bus.ev_ready), 64'd0);
        @(negedge clk);
        bus.all_off = 1'b0;
        #1;
        check("abort_ready_back", 64'(bus.ev_ready), 64'd1);
        @(posedge clk); #1;
        check("abort_no_load", 64'(bus.voice_load), 64'd0);
        check("abort_en_held", 64'(bus.voice_en), 64'd0);
        $display("evt on  note=07 aborted by all_off -> en=%b", bus.voice_en);
        model_reset(1'b1);

        // Steal pointer was cleared by the panic: the next steal hits voice 0.
        run_checked(1'b1, 8'h21);
        run_checked(1'b1, 8'h22);
        run_checked(1'b1, 8'h23);
        run_checked(1'b1, 8'h24);
        run_checked(1'b1, 8'h25);
        check("steal_after_panic", 64'(bus.voice_note[7:0]), 64'h25);

        // Event offered together with all_off is not accepted.
        @(negedge clk);
        bus.ev_valid = 1'b1; bus.ev_on = 1'b1; bus.ev_note = 8'h33; bus.all_off = 1'b1;
        #1;
        check("alloff_ready_low", 64'(bus.ev_ready), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        bus.ev_valid = 1'b0; bus.all_off = 1'b0;
        #1;
        check("alloff_no_accept", 64'(bus.ev_ready), 64'd1);
        model_reset(1'b1);
        @(posedge clk); #1;
        check("alloff_no_load", 64'(bus.voice_load), 64'd0);
        $display("evt on  note=33 offered with all_off -> ready=%b", bus.ev_ready);

        // Asynchronous reset while in COMMIT.
        @(negedge clk);
        bus.ev_valid = 1'b1; bus.ev_on = 1'b1; bus.ev_note = 8'h0A;
        @(posedge clk); #1;
        bus.ev_valid = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("arst_en", 64'(bus.voice_en), 64'd0);
        check("arst_notes", 64'(bus.voice_note), 64'd0);
        check("arst_load", 64'(bus.voice_load), 64'd0);
        check("arst_active", 64'(bus.active_cnt), 64'd0);
        check("arst_steals", 64'(bus.steal_cnt), 64'd0);
        check("arst_ready", 64'(bus.ev_ready), 64'd1);
        $display("evt on  note=0a abandoned by rst -> en=%b", bus.voice_en);
        @(negedge clk);
        rst = 1'b0;
        model_reset(1'b0);
        run_checked(1'b1, 8'h09);

        // Randomized traffic over a small note pool to provoke hits and steals.
        for (int i = 0; i < 150; i++) begin
            int r;
            r = int'($urandom_range(0, 19));
            if (r == 0) pulse_all_off();
            else if (r < 14) run_checked(1'b1, 8'($urandom_range(0, 10)));
            else run_checked(1'b0, 8'($urandom_range(1, 10)));
        end

        // Long run of distinct note-ons to drive the steal counter into saturation.
        for (int k = 0; k < 300; k++) begin
            run_checked(1'b1, 8'((k % 250) + 1));
        end
        check("steal_saturate", 64'(bus.steal_cnt), 64'd255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "timeout");
    end
endmodule
